// File: rtl/elevator_motion.sv
// rtl/elevator_motion.sv - car motion and door controller driven by the selected goal floor
//
// Ports:
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   gf                : goal floor from the goal selector (2'b11 ignored)
//   led1..led3        : pending request lines for floors 1..3
//   floor             : current car floor
//   move_handler      : high while travelling; freezes goal re-selection upstream
//   up, down          : travel direction while moving
//   door_open         : door open indication
//   clr1..clr3        : one-cycle request-clear pulses for the served floor
module elevator_motion #(
    parameter logic [1:0] labelF1       = 2'b00,
    parameter logic [1:0] labelF2       = 2'b01,
    parameter logic [1:0] labelF3       = 2'b10,
    parameter int         TRAVEL_CYCLES = 8,
    parameter int         DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gf,
    input  logic       led1,
    input  logic       led2,
    input  logic       led3,
    output logic [1:0] floor,
    output logic       move_handler,
    output logic       up,
    output logic       down,
    output logic       door_open,
    output logic       clr1,
    output logic       clr2,
    output logic       clr3
);

    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } state_t;

    state_t        state;
    logic [1:0]    target;
    logic [TW-1:0] timer;
    logic [2:0]    clr;

    logic          gf_led;
    logic          floor_led;
    logic [1:0]    next_floor;

    assign clr1 = clr[0];
    assign clr2 = clr[1];
    assign clr3 = clr[2];

    // One-hot clear vector for a floor encoding; invalid encodings clear nothing.
    function automatic logic [2:0] clr_of(input logic [1:0] f);
        logic [2:0] v;
        v = 3'b000;
        if (f == labelF1)      v = 3'b001;
        else if (f == labelF2) v = 3'b010;
        else if (f == labelF3) v = 3'b100;
        return v;
    endfunction

    always_comb begin
        gf_led = 1'b0;
        if (gf == labelF1)      gf_led = led1;
        else if (gf == labelF2) gf_led = led2;
        else if (gf == labelF3) gf_led = led3;

        floor_led = 1'b0;
        if (floor == labelF1)      floor_led = led1;
        else if (floor == labelF2) floor_led = led2;
        else if (floor == labelF3) floor_led = led3;

        // One floor step in the latched direction; never leaves the three valid floors.
        next_floor = floor;
        if (up) begin
            if (floor == labelF1)      next_floor = labelF2;
            else if (floor == labelF2) next_floor = labelF3;
        end else if (down) begin
            if (floor == labelF3)      next_floor = labelF2;
            else if (floor == labelF2) next_floor = labelF1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            floor        <= labelF1;
            target       <= labelF1;
            timer        <= '0;
            move_handler <= 1'b0;
            up           <= 1'b0;
            down         <= 1'b0;
            door_open    <= 1'b0;
            clr          <= 3'b000;
        end else begin
            clr <= 3'b000;
            case (state)
                IDLE: begin
                    if (gf_led) begin
                        timer <= '0;
                        if (gf == floor) begin
                            state     <= DOOR;
                            door_open <= 1'b1;
                            clr       <= clr_of(gf);
                        end else begin
                            state        <= MOVE;
                            target       <= gf;
                            move_handler <= 1'b1;
                            up           <= (gf > floor);
                            down         <= (gf < floor);
                        end
                    end
                end

                MOVE: begin
                    if (timer == TW'(TRAVEL_CYCLES - 1)) begin
                        timer <= '0;
                        floor <= next_floor;
                        if (next_floor == target) begin
                            state        <= DOOR;
                            move_handler <= 1'b0;
                            up           <= 1'b0;
                            down         <= 1'b0;
                            door_open    <= 1'b1;
                            clr          <= clr_of(target);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DOOR: begin
                    // While a clear is in flight the request latch has not dropped yet,
                    // so a high led only counts as a new request once clr is low.
                    if (floor_led && (clr == 3'b000)) begin
                        clr   <= clr_of(floor);
                        timer <= '0;
                    end else if (timer == TW'(DOOR_CYCLES - 1)) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state        <= IDLE;
                    timer        <= '0;
                    move_handler <= 1'b0;
                    up           <= 1'b0;
                    down         <= 1'b0;
                    door_open    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion.sv
// tb/tb_elevator_motion.sv - directed self-checking bench for elevator_motion
module tb_elevator_motion;

    logic       clk;
    logic       rst_n;
    logic [1:0] gf;
    logic       led1, led2, led3;
    logic [1:0] floor;
    logic       move_handler, up, down, door_open;
    logic       clr1, clr2, clr3;

    int checks = 0;
    int errors = 0;

    elevator_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gf           (gf),
        .led1         (led1),
        .led2         (led2),
        .led3         (led3),
        .floor        (floor),
        .move_handler (move_handler),
        .up           (up),
        .down         (down),
        .door_open    (door_open),
        .clr1         (clr1),
        .clr2         (clr2),
        .clr3         (clr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request latches: a clear pulse drops the matching led.
    always @(negedge clk) begin
        if (clr1) led1 = 1'b0;
        if (clr2) led2 = 1'b0;
        if (clr3) led3 = 1'b0;
    end

    task automatic test_reset_values;
        rst_n = 1'b0; gf = 2'b11; led1 = 0; led2 = 0; led3 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({floor, move_handler, up, down, door_open, clr1, clr2, clr3} !== 9'b00_0000000) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b",
                     {floor, move_handler, up, down, door_open, clr1, clr2, clr3}, 9'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_same_floor;
        gf = 2'b00; led1 = 1'b1;
        @(negedge clk);
        gf = 2'b11;
        checks++;
        if ({door_open, clr1, move_handler} !== 3'b110) begin
            errors++;
            $display("FAIL same_floor_entry: got door/clr1/move=%b expected 110", {door_open, clr1, move_handler});
        end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({door_open, clr1, move_handler} !== 3'b100) begin
                errors++;
                $display("FAIL same_floor_hold%0d: got door/clr1/move=%b expected 100", i, {door_open, clr1, move_handler});
            end
        end
        @(negedge clk);
        checks++;
        if ({door_open, move_handler} !== 2'b00) begin
            errors++;
            $display("FAIL same_floor_close: got door/move=%b expected 00", {door_open, move_handler});
        end
    endtask

    task automatic test_travel_up;
        gf = 2'b10; led3 = 1'b1;
        @(negedge clk);
        gf = 2'b11;
        checks++;
        if ({move_handler, up, down, floor} !== 5'b110_00) begin
            errors++;
            $display("FAIL up_start: got move/up/down/floor=%b expected 11000", {move_handler, up, down, floor});
        end
        repeat (7) @(negedge clk);
        checks++;
        if (floor !== 2'b00) begin
            errors++;
            $display("FAIL up_before_step: got floor=%b expected 00", floor);
        end
        @(negedge clk);
        checks++;
        if ({floor, move_handler, door_open} !== 4'b01_10) begin
            errors++;
            $display("FAIL up_pass_f2: got floor/move/door=%b expected 0110", {floor, move_handler, door_open});
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({floor, door_open, clr3, move_handler, up} !== 6'b10_1100) begin
            errors++;
            $display("FAIL up_arrive: got floor/door/clr3/move/up=%b expected 101100", {floor, door_open, clr3, move_handler, up});
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({door_open, clr3} !== 2'b00) begin
            errors++;
            $display("FAIL up_door_close: got door/clr3=%b expected 00", {door_open, clr3});
        end
    endtask

    task automatic test_travel_down_goal_change;
        int clr2_seen;
        clr2_seen = 0;
        gf = 2'b00; led1 = 1'b1;
        @(negedge clk);
        gf = 2'b01; led2 = 1'b1;
        checks++;
        if ({move_handler, up, down} !== 3'b101) begin
            errors++;
            $display("FAIL down_start: got move/up/down=%b expected 101", {move_handler, up, down});
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (clr2) clr2_seen++;
            if (i == 8) begin
                checks++;
                if ({floor, move_handler} !== 3'b01_1) begin
                    errors++;
                    $display("FAIL down_pass_f2: got floor/move=%b expected 011", {floor, move_handler});
                end
            end
        end
        checks++;
        if ({floor, clr1, door_open, move_handler, down} !== 6'b00_1100) begin
            errors++;
            $display("FAIL down_arrive: got floor/clr1/door/move/down=%b expected 001100", {floor, clr1, door_open, move_handler, down});
        end
        checks++;
        if (clr2_seen !== 0) begin
            errors++;
            $display("FAIL down_no_clr2: got %0d clr2 pulses expected 0", clr2_seen);
        end
        gf = 2'b11; led2 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (door_open !== 1'b0) begin
            errors++;
            $display("FAIL down_door_close: got door=%b expected 0", door_open);
        end
    endtask

    task automatic test_door_reopen;
        gf = 2'b01; led2 = 1'b1;
        @(negedge clk);
        gf = 2'b11;
        repeat (8) @(negedge clk);
        checks++;
        if ({floor, door_open, clr2} !== 4'b01_11) begin
            errors++;
            $display("FAIL reopen_arrive: got floor/door/clr2=%b expected 0111", {floor, door_open, clr2});
        end
        repeat (2) @(negedge clk);
        led2 = 1'b1;
        @(negedge clk);
        checks++;
        if ({door_open, clr2} !== 2'b11) begin
            errors++;
            $display("FAIL reopen_clr2: got door/clr2=%b expected 11", {door_open, clr2});
        end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({door_open, clr2} !== 2'b10) begin
                errors++;
                $display("FAIL reopen_hold%0d: got door/clr2=%b expected 10", i, {door_open, clr2});
            end
        end
        @(negedge clk);
        checks++;
        if (door_open !== 1'b0) begin
            errors++;
            $display("FAIL reopen_close: got door=%b expected 0", door_open);
        end
    endtask

    task automatic test_invalid_goal;
        gf = 2'b11; led1 = 1'b1; led2 = 1'b1; led3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({move_handler, door_open, clr1, clr2, clr3, floor} !== 7'b00000_01) begin
                errors++;
                $display("FAIL invalid_goal%0d: got move/door/clr/floor=%b expected 0000001", i,
                         {move_handler, door_open, clr1, clr2, clr3, floor});
            end
        end
        led1 = 1'b0; led2 = 1'b0; led3 = 1'b0;
    endtask

    task automatic test_async_reset_mid_move;
        gf = 2'b10; led3 = 1'b1;
        @(negedge clk);
        gf = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if ({floor, move_handler, up} !== 4'b01_11) begin
            errors++;
            $display("FAIL async_pre: got floor/move/up=%b expected 0111", {floor, move_handler, up});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({floor, move_handler, up, down, door_open} !== 6'b00_0000) begin
            errors++;
            $display("FAIL async_reset: got floor/move/up/down/door=%b expected 000000",
                     {floor, move_handler, up, down, door_open});
        end
        led3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset_values();
        test_same_floor();
        test_travel_up();
        test_travel_down_goal_change();
        test_door_reopen();
        test_invalid_goal();
        test_async_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_motion.md
Name: elevator_motion

Overview:
- Motion/door controller at the consuming end of the goal-floor interface.
- Takes the selected goal floor `gf` plus the pending floor-request lines and moves the car one floor at a time.
- Drives `move_handler` back to the goal selector, which freezes goal re-selection while the car travels.
- On arrival it opens the door for a fixed time and pulses a clear for the served floor's request latch.

Parameters:
- labelF1, 2'b00, encoding of floor 1
- labelF2, 2'b01, encoding of floor 2
- labelF3, 2'b10, encoding of floor 3
- TRAVEL_CYCLES, 8, clock cycles to travel one floor; must be >= 1
- DOOR_CYCLES, 4, clock cycles the door stays open; must be >= 1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- gf  input  2  goal floor from the goal selector; 2'b11 is invalid and ignored
- led1  input  1  pending request, floor 1
- led2  input  1  pending request, floor 2
- led3  input  1  pending request, floor 3
- floor  output  2  current car floor (registered)
- move_handler  output  1  high while the car is travelling (MOVE state only)
- up  output  1  high while moving toward a higher floor
- down  output  1  high while moving toward a lower floor
- door_open  output  1  high in the DOOR state
- clr1  output  1  one-cycle pulse clearing the floor-1 request
- clr2  output  1  one-cycle pulse clearing the floor-2 request
- clr3  output  1  one-cycle pulse clearing the floor-3 request

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; it is applied immediately, including mid-travel or mid-door.
- Reset values:
  - state IDLE, floor=labelF1, target=labelF1, timer=0
  - move_handler=0, up=0, down=0, door_open=0, clr1..3=0
- Floor-to-request map: labelF1↔led1/clr1, labelF2↔led2/clr2, labelF3↔led3/clr3. All outputs are registered.
- IDLE (evaluated every cycle):
  - gf invalid, or the led for gf is low → stay IDLE.
  - gf==floor and its led is high → next cycle DOOR, door_open=1, matching clr pulsed that same cycle.
  - gf!=floor and the led for gf is high → latch target=gf; next cycle MOVE, move_handler=1, up=(gf>floor), down=(gf<floor), timer=0.
- MOVE:
  - timer counts 0..TRAVEL_CYCLES-1.
  - At TRAVEL_CYCLES-1: floor steps ±1 toward target and timer returns to 0.
  - If the new floor==target: on that same edge go to DOOR, move_handler=0, up=down=0, door_open=1, clr for target pulsed one cycle.
  - Otherwise continue; intermediate floors are passed without stopping.
  - gf and led changes are ignored during MOVE because target is latched.
  - Travel F1→F3 takes 2*TRAVEL_CYCLES cycles from MOVE entry.
- DOOR:
  - door_open=1 and move_handler=0, so the goal selector may re-evaluate after the clr drops the led.
  - timer counts 0..DOOR_CYCLES-1, then IDLE with door_open=0.
  - If the current floor's led rises again while in DOOR: pulse that clr again and restart the timer (door reopen).
- clr pulses are exactly one cycle and never asserted for more than one floor in the same cycle.
- floor never leaves {labelF1, labelF2, labelF3}. An unreachable state encoding recovers to IDLE with all outputs low except floor, which is held.
- Timer width: enough bits for max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Test Plan:
- Reset: assert rst_n=0 mid-MOVE at floor=labelF2 → floor=2'b00, move_handler=0, up=down=door_open=0 immediately, without waiting for a clock edge.
- Same-floor request: floor=00, gf=00, led1=1 in IDLE → next cycle door_open=1, clr1=1 for one cycle; door_open stays high 4 cycles, then IDLE; move_handler stays 0 throughout.
- Two-floor travel up: floor=00, gf=10, led3=1 → move_handler=1, up=1 next cycle; floor=01 after 8 cycles; floor=10 after 16 cycles; same edge door_open=1, clr3 pulse, move_handler=0.
- Travel down with goal change: floor=10, gf=00, led1=1; after MOVE starts switch gf=01, led2=1 → car still stops only at 00; clr1 pulses; clr2 never pulses during the trip.
- Door reopen: in DOOR at floor=01, pulse led2 high at door cycle 2 → clr2 pulses again; door_open stays high a further full 4 cycles from the restart.
- Invalid goal: gf=2'b11 with all leds high in IDLE → remains IDLE; no clr pulses, move_handler=0.
